// File: rtl/cvo_seq_pkg.sv
// Shared constants for the CVO reset sequencer: FSM state encoding,
// Avalon register addresses and CTRL/STATUS bit positions.
package cvo_seq_pkg;

  // FSM state encoding (also visible in STATUS[2:0])
  localparam logic [2:0] ST_OFF       = 3'd0;
  localparam logic [2:0] ST_HOLD      = 3'd1;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
  localparam logic [2:0] ST_SETTLE    = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;

  // Avalon word addresses
  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_HOLD   = 3'd2;
  localparam logic [2:0] ADDR_SETTLE = 3'd3;
  localparam logic [2:0] ADDR_RECOV  = 3'd4;

  // CTRL bit indices
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_FORCE  = 2;

endpackage

// File: rtl/cvo_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module cvo_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the async level through two flops; both clear to 0 on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/cvo_reset_sequencer.sv
// CVO reset/enable sequencer with an Avalon-MM register slave.
// Holds the CVO in reset until the video PLL is locked, times the reset
// hold and post-release settle, gates the frame-buffer reader and
// auto-recovers from underflow.
//
// Avalon handshake: zero-wait-state slave. A write is accepted on any clock
// edge where chipselect=1 and write_n=0; readdata is a pure function of
// address and current register state, so there is no valid/ready stall.
// The FSM state is exposed for observation through STATUS[2:0].
module cvo_reset_sequencer
  import cvo_seq_pkg::*;
#(
  parameter int HOLD_W         = 16,
  parameter int HOLD_DEFAULT   = 256,
  parameter int SETTLE_DEFAULT = 1024,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        pll_locked,
  input  logic        cvo_underflow,
  output logic        cvo_reset,
  output logic        fb_enable
);

  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  logic              wr;
  logic              pll_sync;
  logic [1:0]        ctrl_q;
  logic              force_q;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] settle_q;
  logic [HOLD_W-1:0] wr_time;
  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] cnt_d;
  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [CNT_W-1:0]  recov_q;
  logic              recover;
  logic              cvo_reset_q;
  logic              fb_enable_q;

  assign wr = chipselect & ~write_n;

  // A zero timing value would mean "no wait"; it is stored as 1 instead.
  assign wr_time = (writedata[HOLD_W-1:0] == '0) ? HOLD_ONE : writedata[HOLD_W-1:0];

  cvo_sync2 u_pll_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (pll_locked),
    .q_o     (pll_sync)
  );

  // Register file writes; force_reset is a one-cycle pulse seen by the FSM next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q   <= 2'b00;
      force_q  <= 1'b0;
      hold_q   <= HOLD_W'(HOLD_DEFAULT);
      settle_q <= HOLD_W'(SETTLE_DEFAULT);
    end else begin
      force_q <= 1'b0;
      if (wr) begin
        case (address)
          ADDR_CTRL: begin
            ctrl_q  <= writedata[1:0];
            force_q <= writedata[CTRL_FORCE];
          end
          ADDR_HOLD:   hold_q   <= wr_time;
          ADDR_SETTLE: settle_q <= wr_time;
          default: ;
        endcase
      end
    end
  end

  // Next-state logic: exits in priority order, then the normal sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    recover = 1'b0;
    if (!ctrl_q[CTRL_ENABLE]) begin
      state_d = ST_OFF;
    end else if (!pll_sync && (state_q == ST_SETTLE || state_q == ST_RUN)) begin
      state_d = ST_HOLD;
      cnt_d   = hold_q;
    end else if (force_q && state_q != ST_OFF) begin
      state_d = ST_HOLD;
      cnt_d   = hold_q;
    end else if (cvo_underflow && ctrl_q[CTRL_AUTO] && state_q == ST_RUN) begin
      state_d = ST_HOLD;
      cnt_d   = hold_q;
      recover = 1'b1;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_HOLD;
          cnt_d   = hold_q;
        end
        ST_HOLD: begin
          if (cnt_q <= HOLD_ONE) state_d = ST_WAIT_LOCK;
          else                   cnt_d   = cnt_q - HOLD_ONE;
        end
        ST_WAIT_LOCK: begin
          if (pll_sync) begin
            state_d = ST_SETTLE;
            cnt_d   = settle_q;
          end
        end
        ST_SETTLE: begin
          if (cnt_q <= HOLD_ONE) state_d = ST_RUN;
          else                   cnt_d   = cnt_q - HOLD_ONE;
        end
        ST_RUN: ;
        default: state_d = ST_OFF;
      endcase
    end
  end

  // State, shared down-counter and outputs all update on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      cvo_reset_q <= 1'b1;
      fb_enable_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cvo_reset_q <= (state_d == ST_OFF) || (state_d == ST_HOLD) || (state_d == ST_WAIT_LOCK);
      fb_enable_q <= (state_d == ST_RUN);
    end
  end

  // Saturating recovery counter; a software write clears it and beats an increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      recov_q <= '0;
    end else if (wr && address == ADDR_RECOV) begin
      recov_q <= '0;
    end else if (recover && recov_q != '1) begin
      recov_q <= recov_q + CNT_W'(1);
    end
  end

  // Combinational read mux, zero wait states; unused bits and addresses read 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:   readdata[1:0]        = ctrl_q;
      ADDR_STATUS: readdata[5:0]        = {fb_enable_q, cvo_reset_q, pll_sync, state_q};
      ADDR_HOLD:   readdata[HOLD_W-1:0] = hold_q;
      ADDR_SETTLE: readdata[HOLD_W-1:0] = settle_q;
      ADDR_RECOV:  readdata[CNT_W-1:0]  = recov_q;
      default: ;
    endcase
  end

  assign cvo_reset = cvo_reset_q;
  assign fb_enable = fb_enable_q;

endmodule

// File: tb/tb_cvo_reset_sequencer.sv
// Self-checking bench for cvo_reset_sequencer. Expected timings and register
// contents come from the documented rules (hold + one lock cycle, then the
// settle time; zero stored as one; saturating recovery count).
module tb_cvo_reset_sequencer;

  localparam int CNT_W = 4;             // small so saturation is reachable
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [2:0] A_CTRL = 3'd0, A_STATUS = 3'd1, A_HOLD = 3'd2,
                         A_SETTLE = 3'd3, A_RECOV = 3'd4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        pll_locked = 1'b0;
  logic        cvo_underflow = 1'b0;
  logic        cvo_reset;
  logic        fb_enable;

  int checks = 0;
  int errors = 0;
  int m_recov = 0;

  cvo_reset_sequencer #(
    .HOLD_W(16), .HOLD_DEFAULT(256), .SETTLE_DEFAULT(1024), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .pll_locked(pll_locked), .cvo_underflow(cvo_underflow),
    .cvo_reset(cvo_reset), .fb_enable(fb_enable)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic av_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic check_state(input string tag, input logic [2:0] exp);
    logic [31:0] d;
    rd(A_STATUS, d);
    check(tag, {29'd0, d[2:0]}, {29'd0, exp});
  endtask

  // Count cycles after an enabling write until cvo_reset drops and fb_enable rises.
  task automatic measure(input int budget, output int t_rst, output int t_fb);
    t_rst = -1;
    t_fb  = -1;
    for (int k = 1; k <= budget && t_fb < 0; k++) begin
      tick(1);
      if (t_rst < 0 && cvo_reset === 1'b0) t_rst = k;
      if (t_fb < 0 && fb_enable === 1'b1) t_fb = k;
    end
  endtask

  task automatic wait_fb(input string tag, input int budget);
    for (int k = 0; k < budget && fb_enable !== 1'b1; k++) tick(1);
    check(tag, {31'd0, fb_enable}, 32'd1);
  endtask

  task automatic pulse_underflow();
    cvo_underflow = 1'b1;
    tick(1);
    cvo_underflow = 1'b0;
  endtask

  // ---------------- reference model helpers ----------------
  function automatic logic [31:0] m_time(input logic [31:0] v);
    return (v[15:0] == 16'd0) ? 32'd1 : {16'd0, v[15:0]};
  endfunction

  function automatic int m_sat_inc(input int c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 1;
  endfunction

  // ---------------- directed + randomized sequence ----------------
  initial begin
    int t_rst, t_fb, h, s;
    logic [31:0] v;

    // Reset state
    tick(2);
    check("rst_cvo_reset", {31'd0, cvo_reset}, 32'd1);
    check("rst_fb_enable", {31'd0, fb_enable}, 32'd0);
    check_rd("rst_status", A_STATUS, 32'h10);
    reset_n = 1'b1;
    tick(1);
    check_rd("rst_ctrl", A_CTRL, 32'd0);
    check_rd("rst_hold", A_HOLD, 32'd256);
    check_rd("rst_settle", A_SETTLE, 32'd1024);
    check_rd("rst_recov", A_RECOV, 32'd0);
    tick(1);
    check_rd("rd_addr5", 3'd5, 32'd0);
    check_rd("rd_addr6", 3'd6, 32'd0);
    check_rd("rd_addr7", 3'd7, 32'd0);
    pll_locked = 1'b1;
    tick(3);
    check_rd("status_locked_off", A_STATUS, 32'h18);

    // Register behaviour
    av_write(A_HOLD, 32'd0);
    check_rd("hold_zero_as_one", A_HOLD, 32'd1);
    av_write(A_SETTLE, 32'd0);
    check_rd("settle_zero_as_one", A_SETTLE, 32'd1);
    for (int i = 0; i < 3; i++) begin
      v = $urandom();
      av_write(A_HOLD, v);
      check_rd("hold_rand", A_HOLD, m_time(v));
      v = $urandom();
      av_write(A_SETTLE, v);
      check_rd("settle_rand", A_SETTLE, m_time(v));
    end
    av_write(A_CTRL, 32'h6);
    check_rd("ctrl_force_reads0", A_CTRL, 32'h2);
    tick(1);
    check_state("force_in_off_ignored", 3'd0);
    av_write(3'd5, 32'hFFFF_FFFF);
    check_rd("rd_addr5_after_wr", 3'd5, 32'd0);
    av_write(A_CTRL, 32'h0);

    // Directed HOLD=4, SETTLE=8 sequence
    av_write(A_HOLD, 32'd4);
    av_write(A_SETTLE, 32'd8);
    av_write(A_CTRL, 32'h1);
    measure(60, t_rst, t_fb);
    check("seq48_reset_release", t_rst, 32'd6);
    check("seq48_fb_enable", t_fb, 32'd14);
    check_state("seq48_run_state", 3'd4);

    // Randomized HOLD/SETTLE timing against the arithmetic model
    for (int i = 0; i < 4; i++) begin
      h = $urandom_range(1, 12);
      s = $urandom_range(1, 12);
      av_write(A_CTRL, 32'h0);
      av_write(A_HOLD, h);
      av_write(A_SETTLE, s);
      av_write(A_CTRL, 32'h1);
      measure(100, t_rst, t_fb);
      check("rand_reset_release", t_rst, h + 2);
      check("rand_fb_enable", t_fb, h + 2 + s);
    end

    // Waiting for PLL lock
    av_write(A_CTRL, 32'h0);
    pll_locked = 1'b0;
    av_write(A_HOLD, 32'd2);
    av_write(A_SETTLE, 32'd3);
    av_write(A_CTRL, 32'h1);
    tick(10);
    check_state("wait_lock_state", 3'd2);
    check("wait_lock_cvo_reset", {31'd0, cvo_reset}, 32'd1);
    pll_locked = 1'b1;
    tick(2);
    check_state("lock_sync_delay", 3'd2);
    tick(1);
    check_state("lock_to_settle", 3'd3);
    tick(2);
    check("settle_fb_low", {31'd0, fb_enable}, 32'd0);
    tick(1);
    check("settle_fb_high", {31'd0, fb_enable}, 32'd1);

    // PLL loss in RUN
    pll_locked = 1'b0;
    tick(3);
    check_state("pll_loss_hold", 3'd1);
    check("pll_loss_fb", {31'd0, fb_enable}, 32'd0);
    check("pll_loss_cvo_reset", {31'd0, cvo_reset}, 32'd1);
    pll_locked = 1'b1;
    wait_fb("relock_run", 40);

    // PLL loss and disable land in the same cycle: disable wins
    pll_locked = 1'b0;
    tick(1);
    av_write(A_CTRL, 32'h0);
    tick(1);
    check_state("off_beats_pll_loss", 3'd0);
    check("off_cvo_reset", {31'd0, cvo_reset}, 32'd1);
    pll_locked = 1'b1;
    tick(3);

    // Auto-recovery from underflow
    av_write(A_HOLD, 32'd2);
    av_write(A_SETTLE, 32'd2);
    av_write(A_CTRL, 32'h3);
    wait_fb("recov_first_run", 40);
    for (int i = 0; i < 3; i++) begin
      tick(21);
      pulse_underflow();
      m_recov = m_sat_inc(m_recov);
      check_state("recov_to_hold", 3'd1);
      pulse_underflow();             // outside RUN: must be ignored
      wait_fb("recov_back_run", 40);
    end
    check_rd("recov_count3", A_RECOV, m_recov);
    av_write(A_CTRL, 32'h1);
    tick(21);
    pulse_underflow();
    check_state("no_auto_stays_run", 3'd4);
    check_rd("no_auto_count", A_RECOV, m_recov);

    // Clear coincident with an accepted underflow: clear wins
    av_write(A_CTRL, 32'h3);
    tick(2);
    cvo_underflow = 1'b1;
    av_write(A_RECOV, 32'h0);
    cvo_underflow = 1'b0;
    m_recov = 0;
    check_state("clear_coincident_hold", 3'd1);
    check_rd("clear_wins", A_RECOV, m_recov);

    // Saturation
    av_write(A_HOLD, 32'd1);
    av_write(A_SETTLE, 32'd1);
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      wait_fb("sat_run", 40);
      tick($urandom_range(0, 3));
      pulse_underflow();
      m_recov = m_sat_inc(m_recov);
      if (i == 5) check_rd("sat_mid", A_RECOV, m_recov);
    end
    check_rd("sat_all_ones", A_RECOV, CNT_MAX);

    // Reset asserted during SETTLE
    av_write(A_CTRL, 32'h0);
    av_write(A_HOLD, 32'd2);
    av_write(A_SETTLE, 32'd50);
    av_write(A_CTRL, 32'h1);
    tick(6);
    check_state("pre_reset_settle", 3'd3);
    reset_n = 1'b0;
    #1;
    check("async_cvo_reset", {31'd0, cvo_reset}, 32'd1);
    check("async_fb_enable", {31'd0, fb_enable}, 32'd0);
    check_rd("async_status", A_STATUS, 32'h10);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    check_rd("post_rst_hold", A_HOLD, 32'd256);
    check_rd("post_rst_settle", A_SETTLE, 32'd1024);
    check_rd("post_rst_ctrl", A_CTRL, 32'd0);
    tick(1);
    check_rd("post_rst_recov", A_RECOV, 32'd0);
    check_state("post_rst_state", 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
